// File: rtl/spmv_result_drain_pkg.sv
// rtl/spmv_result_drain_pkg.sv - shared widths, FSM encoding and word-count clamp for the result drain
package spmv_result_drain_pkg;

  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 32;
  localparam int DATA_W     = 256;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = DATA_W / BEAT_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int CNT_W      = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_SEND,
    ST_FIN
  } state_t;

  // Requests beyond the SRAM size drain the whole SRAM once.
  function automatic logic [CNT_W-1:0] clamp_words(input logic [CNT_W-1:0] w);
    return (w > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : w;
  endfunction

endpackage

// File: rtl/spmv_result_drain_beat_serializer.sv
// rtl/spmv_result_drain_beat_serializer.sv - splits one SRAM word into valid/ready beats, lowest slice first
module spmv_result_drain_beat_serializer
  import spmv_result_drain_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_last_word,
  input  logic              i_tready,
  output logic [BEAT_W-1:0] o_tdata,
  output logic              o_tvalid,
  output logic              o_tlast,
  output logic              o_done_word
);

  logic [DATA_W-1:0]     buffer;
  logic [BEAT_IDX_W-1:0] beat_idx;
  logic                  handshake;
  logic                  at_last_beat;

  assign handshake    = o_tvalid & i_tready;
  assign at_last_beat = (beat_idx == BEAT_IDX_W'(BEATS - 1));
  assign o_tdata      = buffer[beat_idx*BEAT_W +: BEAT_W];
  assign o_tlast      = o_tvalid & at_last_beat & i_last_word;
  assign o_done_word  = handshake & at_last_beat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buffer   <= '0;
      beat_idx <= '0;
      o_tvalid <= 1'b0;
    end else if (i_load) begin
      buffer   <= i_word;
      beat_idx <= '0;
      o_tvalid <= 1'b1;
    end else if (handshake) begin
      beat_idx <= beat_idx + BEAT_IDX_W'(1);
      if (at_last_beat) o_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/spmv_result_drain.sv
// rtl/spmv_result_drain.sv - drains SpMV result words from SRAM B to the host as 32-bit stream beats
module spmv_result_drain
  import spmv_result_drain_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num_words,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [BEAT_W-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              i_tready,
  output logic              o_tlast,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  state_t           state;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] n_clamped;
  logic             last_word;
  logic             done_word;

  assign n_clamped = clamp_words(i_num_words);
  assign last_word = (word_idx == last_idx);

  spmv_result_drain_beat_serializer u_serializer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (state == ST_CAP),
    .i_word      (i_rd_data),
    .i_last_word (last_word),
    .i_tready    (i_tready),
    .o_tdata     (o_tdata),
    .o_tvalid    (o_tvalid),
    .o_tlast     (o_tlast),
    .o_done_word (done_word)
  );

  // Strobes are set on the transition into their state so they line up with it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      word_idx  <= '0;
      last_idx  <= '0;
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_rd_en <= 1'b0;
      o_done  <= 1'b0;
      if (i_start && state != ST_IDLE) o_overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_overrun <= 1'b0;
            word_idx  <= '0;
            o_busy    <= 1'b1;
            if (n_clamped == '0) begin
              state  <= ST_FIN;
              o_done <= 1'b1;
            end else begin
              last_idx  <= n_clamped - CNT_W'(1);
              state     <= ST_RD;
              o_rd_en   <= 1'b1;
              o_rd_addr <= '0;
            end
          end
        end
        ST_RD:  state <= ST_CAP;
        ST_CAP: state <= ST_SEND;
        ST_SEND: begin
          if (done_word) begin
            if (last_word) begin
              state  <= ST_FIN;
              o_done <= 1'b1;
            end else begin
              word_idx  <= word_idx + CNT_W'(1);
              o_rd_addr <= word_idx[ADDR_W-1:0] + ADDR_W'(1);
              o_rd_en   <= 1'b1;
              state     <= ST_RD;
            end
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_result_drain.sv
// tb/tb_spmv_result_drain.sv - directed self-checking bench for spmv_result_drain
module tb_spmv_result_drain;
  import spmv_result_drain_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [CNT_W-1:0]  i_num_words = '0;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data = '0;
  logic [BEAT_W-1:0] o_tdata;
  logic              o_tvalid;
  logic              i_tready = 1'b0;
  logic              o_tlast;
  logic              o_busy;
  logic              o_done;
  logic              o_overrun;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  spmv_result_drain dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_num_words (i_num_words),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_tdata     (o_tdata),
    .o_tvalid    (o_tvalid),
    .i_tready    (i_tready),
    .o_tlast     (o_tlast),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

  // Word w, beat k holds {w, w, 0, k}; word 0 therefore holds beat k == k.
  function automatic logic [31:0] exp_beat(input int w, input int k);
    return 32'((w << 24) | (w << 16) | k);
  endfunction

  task automatic pulse_start(input logic [CNT_W-1:0] nw);
    @(negedge i_clk);
    i_num_words = nw;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Observes from cycle T+1 until o_done, checking every beat, every read address and stalls.
  task automatic drain(input string name, input int nwords, input bit toggle, input int inject_at);
    int beats = 0;
    int rds = 0;
    int lasts = 0;
    int sends = 0;
    bit stalled = 1'b0;
    bit seen_done = 1'b0;
    logic [31:0] sdata = '0;
    logic        slast = 1'b0;
    logic [31:0] ed;
    logic        el;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      i_start  = 1'b0;
      i_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== sdata || o_tlast !== slast) begin
          errors++;
          $display("FAIL %s stall_hold tvalid=%0b tdata=%h tlast=%0b required tvalid=1 tdata=%h tlast=%0b",
                   name, o_tvalid, o_tdata, o_tlast, sdata, slast);
        end
      end
      stalled = 1'b0;
      if (o_rd_en) begin
        checks++;
        if (o_rd_addr !== rds[ADDR_W-1:0] || rds >= nwords) begin
          errors++;
          $display("FAIL %s rd_addr got=%0d required=%0d (read %0d of %0d)", name, o_rd_addr, rds, rds, nwords);
        end
        rds++;
      end
      if (o_tvalid) begin
        sends++;
        if (inject_at > 0 && sends == inject_at) i_start = 1'b1;
        ed = exp_beat(beats / BEATS, beats % BEATS);
        el = (beats == nwords * BEATS - 1);
        checks++;
        if (o_tdata !== ed || o_tlast !== el) begin
          errors++;
          $display("FAIL %s beat%0d tdata=%h tlast=%0b required tdata=%h tlast=%0b",
                   name, beats, o_tdata, o_tlast, ed, el);
        end
        if (i_tready) begin
          if (o_tlast) lasts++;
          beats++;
        end else begin
          stalled = 1'b1;
          sdata = o_tdata;
          slast = o_tlast;
        end
      end
      if (o_done) seen_done = 1'b1;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    checks++;
    if (!seen_done || beats != nwords * BEATS || rds != nwords || lasts != (nwords > 0 ? 1 : 0)) begin
      errors++;
      $display("FAIL %s totals done=%0b beats=%0d reads=%0d tlasts=%0d required done=1 beats=%0d reads=%0d tlasts=%0d",
               name, seen_done, beats, rds, lasts, nwords * BEATS, nwords, (nwords > 0 ? 1 : 0));
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (o_rd_en !== 1'b0 || o_rd_addr !== '0 || o_tdata !== '0 || o_tvalid !== 1'b0 ||
        o_tlast !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs rd_en=%0b addr=%0d tdata=%h tvalid=%0b tlast=%0b busy=%0b done=%0b overrun=%0b required all 0",
               name, o_rd_en, o_rd_addr, o_tdata, o_tvalid, o_tlast, o_busy, o_done, o_overrun);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    check_all_zero("after_reset_idle");
  endtask

  task automatic test_single_word();
    logic [4:0] got, req;
    pulse_start(1);
    i_tready = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      got = {o_rd_en, o_tvalid, o_tlast, o_done, o_busy};
      req = {t == 1, t >= 3 && t <= 10, t == 10, t == 11, t <= 11};
      checks++;
      if (got !== req) begin
        errors++;
        $display("FAIL single T+%0d {rd_en,tvalid,tlast,done,busy}=%b required %b", t, got, req);
      end
      if (t >= 3 && t <= 10) begin
        checks++;
        if (o_tdata !== 32'(t - 3)) begin
          errors++;
          $display("FAIL single_data T+%0d tdata=%h required %h", t, o_tdata, 32'(t - 3));
        end
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_full_backpressure();
    pulse_start(32);
    drain("full_bp", 32, 1'b1, 0);
  endtask

  task automatic test_clamp();
    pulse_start(63);
    drain("clamp", DEPTH, 1'b0, 0);
  endtask

  task automatic test_zero_words();
    logic [3:0] got, req;
    pulse_start(0);
    got = {o_done, o_busy, o_rd_en, o_tvalid};
    req = 4'b1100;
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL zero_T+1 {done,busy,rd_en,tvalid}=%b required %b", got, req);
    end
    @(negedge i_clk);
    got = {o_done, o_busy, o_rd_en, o_tvalid};
    req = 4'b0000;
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL zero_T+2 {done,busy,rd_en,tvalid}=%b required %b", got, req);
    end
    // A start landing on the FIN cycle is not accepted.
    pulse_start(0);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    got = {o_overrun, o_busy, o_done, o_tvalid};
    req = 4'b1000;
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL start_in_fin {overrun,busy,done,tvalid}=%b required %b", got, req);
    end
  endtask

  task automatic test_overrun();
    pulse_start(4);
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_cleared_by_start got=%0b required 0", o_overrun);
    end
    i_num_words = 6'd9;
    drain("overrun_drain", 4, 1'b0, 5);
    checks++;
    if (o_overrun !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_set overrun=%0b busy=%0b required overrun=1 busy=0", o_overrun, o_busy);
    end
    pulse_start(1);
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got=%0b required 0", o_overrun);
    end
    drain("after_overrun", 1, 1'b0, 0);
  endtask

  task automatic test_reset_mid_drain();
    int beats = 0;
    bit reached = 1'b0;
    bit early_done = 1'b0;
    pulse_start(8);
    i_tready = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (o_done) early_done = 1'b1;
      if (o_tvalid && beats == 3 * BEATS + 4) begin
        reached = 1'b1;
        break;
      end
      if (o_tvalid) beats++;
      @(negedge i_clk);
    end
    checks++;
    if (!reached || early_done || o_tdata !== exp_beat(3, 4)) begin
      errors++;
      $display("FAIL mid_reach reached=%0b early_done=%0b tdata=%h required reached=1 early_done=0 tdata=%h",
               reached, early_done, o_tdata, exp_beat(3, 4));
    end
    i_rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge i_clk);
    check_all_zero("mid_reset_held");
    i_rst = 1'b0;
    pulse_start(2);
    drain("post_reset", 2, 1'b0, 0);
  endtask

  initial begin
    for (int w = 0; w < DEPTH; w++)
      for (int k = 0; k < BEATS; k++)
        mem[w][k*BEAT_W +: BEAT_W] = exp_beat(w, k);
    test_reset();
    test_single_word();
    test_full_backpressure();
    test_clamp();
    test_zero_words();
    test_overrun();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
